sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter.sv | 88 ++++++++
 tb/tb_sram_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter sequencing Wishbone and req/gnt accesses onto SRAM port 0
module sram_port_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_wmask,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        sram_csb0,
  output logic        sram_web0,
  output logic [3:0]  sram_wmask0,
  output logic [7:0]  sram_addr0,
  output logic [31:0] sram_din0,
  input  logic [31:0] sram_dout0
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;
  state_t      r_state;
  logic        r_owner_b;
  logic        r_last_b;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [3:0]  r_mask;
  logic [31:0] r_din;
  logic [31:0] r_wb_dat;
  logic [31:0] r_b_rdata;
  logic        w_a_req;
  logic        w_b_win;
  logic        w_unused;
  assign w_a_req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
  assign w_b_win  = b_req & (~w_a_req | ~r_last_b);
  assign w_unused = ^wbs_adr_i[1:0];
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state   <= IDLE;
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_mask    <= '0;
      r_din     <= '0;
      r_wb_dat  <= '0;
      r_b_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_a_req | b_req) begin
          r_state   <= CMD;
          r_owner_b <= w_b_win;
          r_last_b  <= w_b_win;
          r_we      <= w_b_win ? b_we : wbs_we_i;
          r_addr    <= w_b_win ? b_addr : wbs_adr_i[9:2];
          r_mask    <= w_b_win ? b_wmask : wbs_sel_i;
          r_din     <= w_b_win ? b_wdata : wbs_dat_i;
        end
        CMD: r_state <= r_we ? DONE : WAIT;
        WAIT: begin
          r_state <= DONE;
          if (r_owner_b) r_b_rdata <= sram_dout0;
          else r_wb_dat <= sram_dout0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign sram_csb0   = r_state != CMD;
  assign sram_web0   = ~((r_state == CMD) & r_we);
  assign sram_wmask0 = r_mask;
  assign sram_addr0  = r_addr;
  assign sram_din0   = r_din;
  assign wbs_dat_o   = r_wb_dat;
  assign b_rdata     = r_b_rdata;
  assign wbs_ack_o   = (r_state == DONE) & ~r_owner_b & wbs_cyc_i & wbs_stb_i;
  assign b_rvalid    = (r_state == DONE) & r_owner_b & ~r_we;
  assign b_gnt       = wb_rst_n_i & (r_state == IDLE) & w_b_win;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed self-checking bench with a behavioural SRAM port model
module tb_sram_port_arbiter;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb = 1'b0, wbs_cyc = 1'b0, wbs_we = 1'b0;
  logic [3:0]  wbs_sel = '0;
  logic [31:0] wbs_adr = '0, wbs_dat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [7:0]  b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [3:0]  b_wmask = '0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = '0;
  logic [31:0] mem [256];
  logic [7:0]  cmd_log [256];
  logic        cmd_web_log [256];
  int          cmd_cnt = 0;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_stb_i(wbs_stb), .wbs_cyc_i(wbs_cyc), .wbs_we_i(wbs_we), .wbs_sel_i(wbs_sel),
    .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  always @(posedge clk)
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) mem[sram_addr0][i*8 +: 8] <= sram_din0[i*8 +: 8];
      end else sram_dout0 <= mem[sram_addr0];
    end

  always @(negedge clk)
    if (rst_n && !sram_csb0 && cmd_cnt < 256) begin
      cmd_log[cmd_cnt]     <= sram_addr0;
      cmd_web_log[cmd_cnt] <= sram_web0;
      cmd_cnt              <= cmd_cnt + 1;
    end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_adr = adr; wbs_dat = dat; wbs_sel = sel;
    lat = -1; rd = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wbs_ack_o) begin lat = k; rd = wbs_dat_o; break; end
    end
    @(posedge clk); #1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sram_csb0 !== 1'b1) begin n_err++; $display("FAIL reset_csb0 got %b want 1", sram_csb0); end
    n_cmp++; if (sram_web0 !== 1'b1) begin n_err++; $display("FAIL reset_web0 got %b want 1", sram_web0); end
    n_cmp++; if (sram_wmask0 !== 4'h0) begin n_err++; $display("FAIL reset_wmask0 got %h want 0", sram_wmask0); end
    n_cmp++; if (sram_addr0 !== 8'h00) begin n_err++; $display("FAIL reset_addr0 got %h want 00", sram_addr0); end
    n_cmp++; if (sram_din0 !== 32'h0) begin n_err++; $display("FAIL reset_din0 got %h want 0", sram_din0); end
    n_cmp++; if (wbs_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", wbs_ack_o); end
    n_cmp++; if (wbs_dat_o !== 32'h0) begin n_err++; $display("FAIL reset_wbdat got %h want 0", wbs_dat_o); end
    n_cmp++; if ({b_gnt, b_rvalid} !== 2'b00) begin n_err++; $display("FAIL reset_b_pulses got %b want 00", {b_gnt, b_rvalid}); end
    n_cmp++; if (b_rdata !== 32'h0) begin n_err++; $display("FAIL reset_b_rdata got %h want 0", b_rdata); end
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_wb_write_read();
    int lat, s;
    logic [31:0] rd;
    s = cmd_cnt;
    wb_xfer(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, lat, rd);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wb_write_latency got %0d want 2", lat); end
    n_cmp++; if (cmd_log[s] !== 8'h04 || cmd_web_log[s] !== 1'b0) begin n_err++; $display("FAIL wb_write_cmd got addr %h web %b want addr 04 web 0", cmd_log[s], cmd_web_log[s]); end
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, lat, rd);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wb_read_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL wb_read_data got %h want deadbeef", rd); end
    n_cmp++; if (cmd_log[s+1] !== 8'h04 || cmd_web_log[s+1] !== 1'b1) begin n_err++; $display("FAIL wb_read_cmd got addr %h web %b want addr 04 web 1", cmd_log[s+1], cmd_web_log[s+1]); end
    n_cmp++; if (cmd_cnt !== s + 2) begin n_err++; $display("FAIL wb_cmd_count got %0d want %0d", cmd_cnt - s, 2); end
  endtask

  task automatic test_byte_mask();
    int lat;
    logic [31:0] rd;
    wb_xfer(1'b1, BASE + 32'h14, 32'hAABBCCDD, 4'hF, lat, rd);
    wb_xfer(1'b1, BASE + 32'h14, 32'h11223344, 4'h5, lat, rd);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL mask_write_latency got %0d want 2", lat); end
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, lat, rd);
    n_cmp++; if (rd !== 32'hAA22CC44) begin n_err++; $display("FAIL mask_readback got %h want aa22cc44", rd); end
  endtask

  task automatic test_zero_mask();
    int lat;
    logic [31:0] rd;
    wb_xfer(1'b1, BASE + 32'h14, 32'hFFFFFFFF, 4'h0, lat, rd);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL zero_mask_ack got latency %0d want 2", lat); end
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, lat, rd);
    n_cmp++; if (rd !== 32'hAA22CC44) begin n_err++; $display("FAIL zero_mask_readback got %h want aa22cc44", rd); end
  endtask

  task automatic test_non_hit();
    int lat, s;
    logic [31:0] rd;
    s = cmd_cnt;
    wb_xfer(1'b0, 32'h2000_0010, 32'h0, 4'hF, lat, rd);
    n_cmp++; if (lat !== -1) begin n_err++; $display("FAIL non_hit_ack got latency %0d want none", lat); end
    n_cmp++; if (cmd_cnt !== s) begin n_err++; $display("FAIL non_hit_cmds got %0d want 0", cmd_cnt - s); end
  endtask

  task automatic test_b_read();
    int lat, gk, rk, ng;
    logic [31:0] rd, rv;
    wb_xfer(1'b1, BASE + 32'h3FC, 32'hCAFEF00D, 4'hF, lat, rd);
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'hFF;
    gk = -1; rk = -1; ng = 0; rv = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b_gnt) begin ng++; if (gk < 0) gk = k; end
      if (b_rvalid && rk < 0) begin rk = k; rv = b_rdata; end
      @(posedge clk); #1;
      if (gk >= 0) b_req = 1'b0;
    end
    n_cmp++; if (gk !== 0) begin n_err++; $display("FAIL b_gnt_cycle got %0d want 0", gk); end
    n_cmp++; if (ng !== 1) begin n_err++; $display("FAIL b_gnt_count got %0d want 1", ng); end
    n_cmp++; if (rk - gk !== 3) begin n_err++; $display("FAIL b_rvalid_delay got %0d want 3", rk - gk); end
    n_cmp++; if (rv !== 32'hCAFEF00D) begin n_err++; $display("FAIL b_rdata got %h want cafef00d", rv); end
  endtask

  task automatic test_abort();
    int lat, na;
    logic [31:0] rd;
    @(posedge clk); #1;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = BASE + 32'h10; wbs_sel = 4'hF;
    @(posedge clk);
    @(posedge clk); #1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    na = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (wbs_ack_o) na++; end
    n_cmp++; if (na !== 0) begin n_err++; $display("FAIL abort_ack got %0d acks want 0", na); end
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, lat, rd);
    n_cmp++; if (lat !== 3 || rd !== 32'hAA22CC44) begin n_err++; $display("FAIL after_abort_read got lat %0d data %h want lat 3 data aa22cc44", lat, rd); end
  endtask

  task automatic test_contention();
    int s, ng, na;
    logic g0;
    pulse_reset();
    s = cmd_cnt;
    @(posedge clk); #1;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = BASE + 32'h80; wbs_dat = 32'hA5A5A5A5; wbs_sel = 4'hF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h21; b_wdata = 32'h5A5A5A5A; b_wmask = 4'hF;
    ng = 0; na = 0; g0 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) g0 = b_gnt;
      if (b_gnt) ng++;
      if (wbs_ack_o) na++;
    end
    @(posedge clk); #1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; b_req = 1'b0;
    n_cmp++; if (g0 !== 1'b0) begin n_err++; $display("FAIL contention_first_gnt got b_gnt %b want 0", g0); end
    n_cmp++; if ({cmd_log[s], cmd_log[s+1], cmd_log[s+2], cmd_log[s+3]} !== 32'h20212021) begin n_err++; $display("FAIL contention_order got %h want 20212021", {cmd_log[s], cmd_log[s+1], cmd_log[s+2], cmd_log[s+3]}); end
    n_cmp++; if (ng !== 2 || na !== 2) begin n_err++; $display("FAIL contention_pulses got gnt %0d ack %0d want 2 2", ng, na); end
    n_cmp++; if (mem[8'h21] !== 32'h5A5A5A5A) begin n_err++; $display("FAIL contention_b_write got %h want 5a5a5a5a", mem[8'h21]); end
  endtask

  task automatic test_reset_mid_read();
    int s, na;
    logic g0;
    @(posedge clk); #1;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = BASE + 32'h10; wbs_sel = 4'hF;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin n_err++; $display("FAIL midreset_cs got csb %b web %b want 1 1", sram_csb0, sram_web0); end
    n_cmp++; if ({sram_addr0, sram_wmask0, sram_din0} !== 44'h0) begin n_err++; $display("FAIL midreset_bus got addr %h mask %h din %h want 0", sram_addr0, sram_wmask0, sram_din0); end
    n_cmp++; if ({wbs_dat_o, b_rdata} !== 64'h0) begin n_err++; $display("FAIL midreset_rdata got wb %h b %h want 0 0", wbs_dat_o, b_rdata); end
    n_cmp++; if ({wbs_ack_o, b_gnt, b_rvalid} !== 3'b000) begin n_err++; $display("FAIL midreset_pulses got %b want 000", {wbs_ack_o, b_gnt, b_rvalid}); end
    wbs_cyc = 1'b0; wbs_stb = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    s = cmd_cnt; na = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (wbs_ack_o) na++; end
    n_cmp++; if (na !== 0 || cmd_cnt !== s) begin n_err++; $display("FAIL midreset_after got acks %0d cmds %0d want 0 0", na, cmd_cnt - s); end
    @(posedge clk); #1;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = BASE + 32'hC0; wbs_dat = 32'h01020304; wbs_sel = 4'hF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h31; b_wdata = 32'h0A0B0C0D; b_wmask = 4'hF;
    g0 = 1'b0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (k == 0) g0 = b_gnt; end
    @(posedge clk); #1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; b_req = 1'b0;
    n_cmp++; if (g0 !== 1'b0 || cmd_log[s] !== 8'h30) begin n_err++; $display("FAIL midreset_contention got gnt %b first addr %h want 0 30", g0, cmd_log[s]); end
    n_cmp++; if (cmd_log[s+1] !== 8'h31) begin n_err++; $display("FAIL midreset_second got addr %h want 31", cmd_log[s+1]); end
  endtask

  initial begin
    test_reset();
    test_wb_write_read();
    test_byte_mask();
    test_zero_mask();
    test_non_hit();
    test_b_read();
    test_abort();
    test_contention();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
